bp_cce_pending_table: RTL



---
 rtl/bp_cce_pending_table_if.sv | 49 ++++
 rtl/bp_cce_pending_table.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bp_cce_pending_table_if.sv
// ----------------------------------------------------------------------------
// bp_cce_pending_table_if
//
// Purpose: groups the pending-table write request, read request and read
// response signals so they can be passed as a single port.
//
// Handshake: valid-only, with no ready/backpressure. A request is taken
// on the rising edge where its valid is high and the table is not busy.
// Requests presented while busy are dropped, not stalled. The read response
// (pending_o) is meaningful only in a cycle where pending_v_o is high. That
// cycle is exactly one cycle after the accepted read.
//
// Signals:
//   pending_w_v_i            write valid
//   pending_w_addr_i         write address
//   pending_w_addr_bypass_i  accepted, no effect
//   pending_i                1 = increment, 0 = decrement
//   pending_r_v_i            read valid
//   pending_r_addr_i         read address
//   pending_r_addr_bypass_i  forward a same-cycle write to the read
//   pending_o                addressed counter non-zero
//   pending_v_o              pending_o valid
// Modports: master drives requests, slave (the table) drives the response.
// ----------------------------------------------------------------------------
interface bp_cce_pending_table_if #(
    parameter int paddr_width_p = 40
);
    logic                     pending_w_v_i;
    logic [paddr_width_p-1:0] pending_w_addr_i;
    logic                     pending_w_addr_bypass_i;
    logic                     pending_i;
    logic                     pending_r_v_i;
    logic [paddr_width_p-1:0] pending_r_addr_i;
    logic                     pending_r_addr_bypass_i;
    logic                     pending_o;
    logic                     pending_v_o;

    modport master (
        output pending_w_v_i, pending_w_addr_i, pending_w_addr_bypass_i, pending_i,
        output pending_r_v_i, pending_r_addr_i, pending_r_addr_bypass_i,
        input  pending_o, pending_v_o
    );

    modport slave (
        input  pending_w_v_i, pending_w_addr_i, pending_w_addr_bypass_i, pending_i,
        input  pending_r_v_i, pending_r_addr_i, pending_r_addr_bypass_i,
        output pending_o, pending_v_o
    );
endinterface

// File: rtl/bp_cce_pending_table.sv
// ----------------------------------------------------------------------------
// bp_cce_pending_table
//
// Purpose: holds one saturating pending counter per way group. It serves one
// increment/decrement write and one "count non-zero" read per cycle. The read
// result is registered and has an optional same-cycle write bypass. A sweep
// FSM zeroes one counter per cycle. Sticky flags record an increment at max
// (overflow) and a decrement at zero (underflow).
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   clear_i        start a clear sweep (sampled only when not busy)
//   busy_o         sweep in progress; reads and writes are dropped
//   overflow_o     sticky: increment attempted at max count
//   underflow_o    sticky: decrement attempted at zero
//   debug_state_o  current FSM state (0 = READY, 1 = CLEAR)
//   bus            read/write request and read response (slave side)
// ----------------------------------------------------------------------------
module bp_cce_pending_table #(
    parameter int paddr_width_p       = 40,
    parameter int block_offset_bits_p = 6,
    parameter int num_way_groups_p    = 64,
    parameter int pending_cnt_width_p = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    output logic busy_o,
    output logic overflow_o,
    output logic underflow_o,
    output logic debug_state_o,
    bp_cce_pending_table_if.slave bus
);

    localparam int wg_bits_lp = $clog2(num_way_groups_p);
    localparam logic [pending_cnt_width_p-1:0] cnt_max_lp = '1;
    localparam logic [wg_bits_lp-1:0] last_idx_lp = wg_bits_lp'(num_way_groups_p - 1);

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                   state_q, state_n;
    logic [wg_bits_lp-1:0]    clr_idx_q, clr_idx_n;
    logic [pending_cnt_width_p-1:0] cnt_q [num_way_groups_p];

    logic                     ready;
    logic                     w_fire, r_fire;
    logic [wg_bits_lp-1:0]    wg_w, wg_r;
    logic [pending_cnt_width_p-1:0] w_cur, w_post;
    logic                     w_at_max, w_at_zero;
    logic                     r_result;

    // The block offset and the bits above the way-group index do not select
    // a counter. The write-side bypass input has no effect.
    logic unused_ok;
    assign unused_ok = ^{bus.pending_w_addr_bypass_i,
                         bus.pending_w_addr_i[paddr_width_p-1:block_offset_bits_p+wg_bits_lp],
                         bus.pending_w_addr_i[block_offset_bits_p-1:0],
                         bus.pending_r_addr_i[paddr_width_p-1:block_offset_bits_p+wg_bits_lp],
                         bus.pending_r_addr_i[block_offset_bits_p-1:0]};

    assign wg_w   = bus.pending_w_addr_i[block_offset_bits_p +: wg_bits_lp];
    assign wg_r   = bus.pending_r_addr_i[block_offset_bits_p +: wg_bits_lp];
    assign ready  = (state_q == READY);
    assign w_fire = ready & bus.pending_w_v_i;
    assign r_fire = ready & bus.pending_r_v_i;

    assign busy_o        = (state_q == CLEAR);
    assign debug_state_o = (state_q == CLEAR);

    // Saturating update: the counter holds at either end instead of wrapping.
    assign w_cur     = cnt_q[wg_w];
    assign w_at_max  = (w_cur == cnt_max_lp);
    assign w_at_zero = (w_cur == '0);
    assign w_post    = bus.pending_i ? (w_at_max  ? w_cur : w_cur + 1'b1)
                                     : (w_at_zero ? w_cur : w_cur - 1'b1);

    // A bypassed read to the written way group sees the post-write value.
    always_comb begin
        r_result = (cnt_q[wg_r] != '0);
        if (bus.pending_r_addr_bypass_i && bus.pending_w_v_i && (wg_w == wg_r)) begin
            r_result = (w_post != '0);
        end
    end

    // Next-state logic for the clear sweep.
    always_comb begin
        state_n   = state_q;
        clr_idx_n = clr_idx_q;
        case (state_q)
            READY: begin
                if (clear_i) begin
                    state_n   = CLEAR;
                    clr_idx_n = '0;
                end
            end
            CLEAR: begin
                clr_idx_n = clr_idx_q + 1'b1;
                if (clr_idx_q == last_idx_lp) begin
                    state_n   = READY;
                    clr_idx_n = '0;
                end
            end
            default: begin
                state_n   = READY;
                clr_idx_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= READY;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_n;
            clr_idx_q <= clr_idx_n;
        end
    end

    // While the sweep runs it owns the array, so writes are ignored.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_way_groups_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            cnt_q[clr_idx_q] <= '0;
        end else if (w_fire) begin
            cnt_q[wg_w] <= w_post;
        end
    end

    // Entering a sweep clears the flags, even if a faulting write is accepted
    // in that same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (ready && clear_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (w_fire) begin
            if (bus.pending_i && w_at_max) begin
                overflow_o <= 1'b1;
            end
            if (!bus.pending_i && w_at_zero) begin
                underflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.pending_v_o <= 1'b0;
            bus.pending_o   <= 1'b0;
        end else begin
            bus.pending_v_o <= r_fire;
            bus.pending_o   <= r_fire ? r_result : 1'b0;
        end
    end

endmodule
